// File: rtl/prog_timer_pkg.sv
// Shared definitions for the programmable timer: register map and CTRL layout.
package prog_timer_pkg;

    // Register offsets selected by addr[1:0]
    typedef enum logic [1:0] {
        REG_LOAD   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_e;

    // CTRL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_MODE    = 1;
    localparam int unsigned CTRL_IE      = 2;
    localparam int unsigned CTRL_PRE_LSB = 8;
    localparam int unsigned CTRL_PRE_MSB = 15;
    localparam int unsigned PRE_W        = CTRL_PRE_MSB - CTRL_PRE_LSB + 1;

    // Assemble the CTRL read value; unused bits [7:3] read as zero
    function automatic logic [15:0] pack_ctrl(input logic en, input logic mode,
                                              input logic ie, input logic [PRE_W-1:0] pre);
        logic [15:0] r;
        r = '0;
        r[CTRL_EN]                   = en;
        r[CTRL_MODE]                 = mode;
        r[CTRL_IE]                   = ie;
        r[CTRL_PRE_MSB:CTRL_PRE_LSB] = pre;
        return r;
    endfunction

endpackage

// File: rtl/prog_timer_chan.sv
// One timer channel: LOAD/CTRL/COUNT/STATUS registers, prescaler and down-counter.
module timer_chan
    import prog_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_load_i,
    input  logic        wr_ctrl_i,
    input  logic        wr_status_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] load_o,
    output logic [15:0] count_o,
    output logic [15:0] ctrl_o,
    output logic [15:0] status_o,
    output logic        expire_o,
    output logic        irq_o
);

    logic [WIDTH-1:0] load_q,  load_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [PRE_W-1:0] psc_q,   psc_d;
    logic             en_q,    en_d;
    logic             mode_q,  mode_d;
    logic             ie_q,    ie_d;
    logic             pend_q,  pend_d;
    logic             expire_q, expire_d;
    logic             tick;

    // Next-state: prescaler/counter advance first, then register writes override
    always_comb begin
        load_d   = load_q;
        count_d  = count_q;
        pre_d    = pre_q;
        psc_d    = psc_q;
        en_d     = en_q;
        mode_d   = mode_q;
        ie_d     = ie_q;
        expire_d = 1'b0;

        // A LOAD write in the same cycle swallows the tick entirely
        tick = en_q && (psc_q == pre_q) && !wr_load_i;

        if (en_q) begin
            psc_d = (psc_q == pre_q) ? '0 : psc_q + PRE_W'(1);
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expire_d = 1'b1;
                if (mode_q) begin
                    count_d = load_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr_ctrl_i) begin
            en_d   = wdata_i[CTRL_EN];
            mode_d = wdata_i[CTRL_MODE];
            ie_d   = wdata_i[CTRL_IE];
            pre_d  = wdata_i[CTRL_PRE_MSB:CTRL_PRE_LSB];
            if (!en_q && wdata_i[CTRL_EN]) begin
                count_d = load_q;
                psc_d   = '0;
            end
        end

        if (wr_load_i) begin
            load_d  = wdata_i[WIDTH-1:0];
            count_d = wdata_i[WIDTH-1:0];
            psc_d   = '0;
        end

        // Expiry set takes priority over write-1-to-clear
        pend_d = (pend_q && !(wr_status_i && wdata_i[0])) || expire_d;
    end

    // Channel state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_q   <= '0;
            count_q  <= '0;
            pre_q    <= '0;
            psc_q    <= '0;
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            ie_q     <= 1'b0;
            pend_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            load_q   <= load_d;
            count_q  <= count_d;
            pre_q    <= pre_d;
            psc_q    <= psc_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            expire_q <= expire_d;
        end
    end

    assign load_o   = 16'(load_q);
    assign count_o  = 16'(count_q);
    assign ctrl_o   = pack_ctrl(en_q, mode_q, ie_q, pre_q);
    assign status_o = {15'b0, pend_q};
    assign expire_o = expire_q;
    assign irq_o    = pend_q && ie_q;

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer: address decode, read mux and interrupt OR.
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [1+$clog2(NCH):0] addr,
    input  logic [15:0]            wdata,
    output logic [15:0]            rdata,
    output logic [NCH-1:0]         expire,
    output logic [NCH-1:0]         irq,
    output logic                   irq_any
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0] ch_sel;
    reg_off_e      reg_sel;
    logic [15:0]   ch_load   [NCH];
    logic [15:0]   ch_count  [NCH];
    logic [15:0]   ch_ctrl   [NCH];
    logic [15:0]   ch_status [NCH];

    assign reg_sel = reg_off_e'(addr[1:0]);

    // A single-channel build has no channel-select bits in addr
    if (NCH > 1) begin : g_sel
        assign ch_sel = addr[1+$clog2(NCH):2];
    end else begin : g_sel_one
        assign ch_sel = '0;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        logic hit;
        assign hit = we && (ch_sel == CW'(g));

        timer_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk_i      (clk),
            .rst_ni     (reset),
            .wr_load_i  (hit && (reg_sel == REG_LOAD)),
            .wr_ctrl_i  (hit && (reg_sel == REG_CTRL)),
            .wr_status_i(hit && (reg_sel == REG_STATUS)),
            .wdata_i    (wdata),
            .load_o     (ch_load[g]),
            .count_o    (ch_count[g]),
            .ctrl_o     (ch_ctrl[g]),
            .status_o   (ch_status[g]),
            .expire_o   (expire[g]),
            .irq_o      (irq[g])
        );
    end

    // Combinational read of the addressed channel register
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_sel == CW'(i)) begin
                case (reg_sel)
                    REG_LOAD:   rdata = ch_load[i];
                    REG_CTRL:   rdata = ch_ctrl[i];
                    REG_COUNT:  rdata = ch_count[i];
                    REG_STATUS: rdata = ch_status[i];
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_prog_timer.sv
// Directed self-checking bench for prog_timer with a per-channel expiry scoreboard.
module tb_prog_timer;

    localparam int LD = 0;
    localparam int CT = 1;
    localparam int CN = 2;
    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  expire;
    logic [3:0]  irq;
    logic        irq_any;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned exp_q [4][$];

    prog_timer #(.NCH(4), .WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .expire (expire),
        .irq    (irq),
        .irq_any(irq_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] mk(input int ch, input int r);
        return 4'(ch * 4 + r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every channel's expire against the scoreboard for the current cycle
    task automatic mon();
        for (int c = 0; c < 4; c++) begin
            logic want;
            want = 1'b0;
            if (exp_q[c].size() > 0) begin
                if (exp_q[c][0] == cyc) begin
                    want = 1'b1;
                    void'(exp_q[c].pop_front());
                end
            end
            chk($sformatf("expire%0d_cyc%0d", c, cyc), 32'(expire[c]), 32'(want));
        end
    endtask

    task automatic push(input int c, input int unsigned first, input int unsigned per,
                        input int unsigned last);
        for (int unsigned t = first; t <= last; t += per) exp_q[c].push_back(t);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            mon();
        end
    endtask

    task automatic wr(input int ch, input int r, input logic [15:0] d);
        @(negedge clk);
        we    = 1'b1;
        addr  = mk(ch, r);
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        mon();
    endtask

    task automatic rd_chk(input string tag, input int ch, input int r, input logic [15:0] exp);
        addr = mk(ch, r);
        #1;
        chk(tag, 32'(rdata), 32'(exp));
    endtask

    initial begin
        int unsigned a0;
        int unsigned a;
        int unsigned h;

        reset = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_expire", 32'(expire), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_irq_any", 32'(irq_any), 32'h0);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_chk($sformatf("rst_reg_c%0d_r%0d", c, r), c, r, 16'h0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        run(2);

        // ch0 periodic, LOAD=4, PRE=0, IE=0: expire every 5 cycles
        wr(0, LD, 16'd4);
        wr(0, CT, 16'h0003);
        a = cyc;
        push(0, a + 5, 5, a + 15);
        run(15);
        rd_chk("a_pending", 0, ST, 16'h0001);
        chk("a_irq", 32'(irq), 32'h0);
        chk("a_irq_any", 32'(irq_any), 32'h0);
        rd_chk("a_load", 0, LD, 16'd4);
        wr(0, CT, 16'h0000);
        wr(0, ST, 16'h0000);
        rd_chk("a_w0_no_clear", 0, ST, 16'h0001);
        wr(0, ST, 16'h0001);
        rd_chk("a_w1_clear", 0, ST, 16'h0000);

        // ch1 one-shot, LOAD=2, PRE=3, IE=1 (bits 7:3 written but read back 0)
        wr(1, LD, 16'd2);
        wr(1, CT, 16'h03FD);
        a = cyc;
        push(1, a + 12, 12, a + 12);
        run(11);
        chk("b_irq_early", 32'(irq), 32'h0);
        run(1);
        chk("b_irq", 32'(irq), 32'h2);
        chk("b_irq_any", 32'(irq_any), 32'h1);
        rd_chk("b_ctrl_en_off", 1, CT, 16'h0304);
        rd_chk("b_count", 1, CN, 16'h0000);
        wr(1, CN, 16'h0055);
        rd_chk("b_count_ro", 1, CN, 16'h0000);
        run(20);
        chk("b_irq_hold", 32'(irq), 32'h2);
        wr(1, ST, 16'h0000);
        chk("b_irq_w0", 32'(irq), 32'h2);
        wr(1, ST, 16'h0001);
        chk("b_irq_clr", 32'(irq), 32'h0);
        chk("b_irq_any_clr", 32'(irq_any), 32'h0);

        // Clear written on the same edge as an expiry: set wins
        wr(0, CT, 16'h0003);
        a = cyc;
        push(0, a + 5, 5, a + 5);
        run(4);
        wr(0, ST, 16'h0001);
        rd_chk("c_set_wins", 0, ST, 16'h0001);
        wr(0, ST, 16'h0001);
        rd_chk("c_clear_after", 0, ST, 16'h0000);
        wr(0, CT, 16'h0000);

        // All four channels periodic, LOAD=1,3,5,7, PRE=0; ch0 with IE
        wr(0, LD, 16'd1);
        wr(1, LD, 16'd3);
        wr(2, LD, 16'd5);
        wr(3, LD, 16'd7);
        wr(0, CT, 16'h0007);
        a0 = cyc;
        // Arming writes land on consecutive edges, so ch1 arms at a0+1 and pulses at a0+37
        h = a0 + 37;
        push(0, a0 + 2, 2, h);
        wr(1, CT, 16'h0003);
        push(1, cyc + 4, 4, h);
        wr(2, CT, 16'h0003);
        push(2, cyc + 6, 6, h);
        wr(3, CT, 16'h0003);
        push(3, cyc + 8, 8, h);
        run(int'(h - cyc));

        // Reset mid-count while ch1 holds COUNT=3
        rd_chk("r_count_pre", 1, CN, 16'd3);
        chk("r_irq_pre", 32'(irq), 32'h1);
        chk("r_irq_any_pre", 32'(irq_any), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("r_expire", 32'(expire), 32'h0);
        chk("r_irq", 32'(irq), 32'h0);
        chk("r_irq_any", 32'(irq_any), 32'h0);
        rd_chk("r_count", 1, CN, 16'h0000);
        for (int c = 0; c < 4; c++) exp_q[c].delete();
        run(2);
        @(negedge clk);
        reset = 1'b1;
        run(50);
        rd_chk("r_count_idle", 1, CN, 16'h0000);
        rd_chk("r_ctrl_idle", 0, CT, 16'h0000);
        rd_chk("r_load_idle", 3, LD, 16'h0000);
        chk("r_irq_idle", 32'(irq), 32'h0);

        // ch2 LOAD=0, PRE=0, periodic: expire every cycle; LOAD write suppresses one
        wr(2, CT, 16'h0003);
        a = cyc;
        push(2, a + 1, 1, a + 6);
        run(4);
        rd_chk("d_count", 2, CN, 16'h0000);
        run(2);
        wr(2, LD, 16'h0000);
        push(2, a + 8, 1, a + 10);
        run(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning number of independent timer channels (1..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning counter and reload width (1..16).
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: asynchronous, active-low reset.
REQ-005 Port we SHALL be input, 1 bit: register write strobe, sampled on the rising edge of clk.
REQ-006 Port addr SHALL be input, 2+clog2(NCH) bits: addr[1:0] selects the register (0 LOAD, 1 CTRL, 2 COUNT, 3 STATUS); the upper bits select the channel.
REQ-007 Port wdata SHALL be input, 16 bits: write data.
REQ-008 Port rdata SHALL be output, 16 bits: combinational read of the addressed register, zero-extended.
REQ-009 Port expire SHALL be output, NCH bits: one-cycle pulse per channel on expiry.
REQ-010 Port irq SHALL be output, NCH bits: per-channel level interrupt, pending AND IE.
REQ-011 Port irq_any SHALL be output, 1 bit: OR of irq.

Function
REQ-012 CTRL fields SHALL be: bit0 EN, bit1 MODE (0 one-shot, 1 periodic), bit2 IE, bits[15:8] PRE (prescale divisor is PRE+1); bits[7:3] read as 0.
REQ-013 A LOAD write SHALL update LOAD[WIDTH-1:0], copy it into COUNT, and clear the prescale counter, in the same edge.
REQ-014 A CTRL write that changes EN from 0 to 1 SHALL copy LOAD into COUNT and clear the prescale counter.
REQ-015 Writes to COUNT SHALL be ignored.
REQ-016 STATUS bit0 SHALL read the pending flag; writing 1 to bit0 clears it, writing 0 has no effect.
REQ-017 While EN=1, the prescale counter SHALL increment each cycle and produce a tick when it equals PRE, then wrap to 0; while EN=0 it holds.
REQ-018 On a tick with COUNT>0, COUNT SHALL decrement by 1.
REQ-019 On a tick with COUNT==0, the channel SHALL assert expire for one cycle and set pending; in periodic mode COUNT reloads from LOAD; in one-shot mode EN clears and COUNT stays 0.
REQ-020 The expiry period SHALL be exactly (LOAD+1)*(PRE+1) cycles, measured from arming to the expire pulse.
REQ-021 LOAD=0 with PRE=0 in periodic mode SHALL give expire every cycle.
REQ-022 If expiry and a STATUS write-1-to-clear occur in the same cycle, set SHALL win.
REQ-023 If a LOAD write and a tick occur in the same cycle, the write SHALL win and no expire is produced.
REQ-024 Channels SHALL be fully independent; a write affects only the addressed channel.
REQ-025 irq SHALL be registered-flag driven, with no combinational path from we/wdata to irq.

Reset
REQ-026 While reset=0, the block SHALL hold LOAD, COUNT, CTRL, pending and the prescale counters at 0, with expire=0, irq=0 and irq_any=0.
REQ-027 Reset asserted mid-count SHALL abort immediately; after release, channels stay idle until EN is written.

Structure
REQ-028 A shared package SHALL hold the register offsets (LOAD/CTRL/COUNT/STATUS) and the CTRL bit positions (EN, MODE, IE, PRE_LSB, PRE_MSB).
REQ-029 Per-channel logic SHALL be one sub-module, timer_chan, instantiated NCH times with a generate loop; the top level does only address decode, read mux and irq OR.

Verification
REQ-030 The bench SHALL cover: ch0 LOAD=4, CTRL=EN|periodic, PRE=0 -> expire[0] every 5 cycles, pending=1, irq[0]=0 (IE=0).
REQ-031 The bench SHALL cover: ch1 LOAD=2, PRE=3, one-shot, IE=1 -> single expire 12 cycles after arming, EN reads 0, irq[1]=irq_any=1 until STATUS is written with 1.
REQ-032 The bench SHALL cover: STATUS clear written in the same cycle as an expiry -> pending stays 1.
REQ-033 The bench SHALL cover: LOAD=0, PRE=0, periodic -> expire held high every cycle, COUNT reads 0.
REQ-034 The bench SHALL cover: reset pulled low at COUNT=3 -> all outputs 0 at once; after release, COUNT stays 0 and no expire occurs for 50 cycles.
REQ-035 The bench SHALL cover: all 4 channels armed with LOAD=1,3,5,7, PRE=0 -> expire periods of 2, 4, 6, 8 cycles with no cross-talk.
